// File: rtl/psram_qpi_responder_pkg.sv
// Shared definitions for the ESP-PSRAM64H target model: opcodes, burst timing,
// FSM state encoding and the in-page linear address increment.
package psram_qpi_responder_pkg;

  localparam logic [7:0] OP_RSTEN     = 8'h66;
  localparam logic [7:0] OP_RST       = 8'h99;
  localparam logic [7:0] OP_ENTER_QPI = 8'h35;
  localparam logic [7:0] OP_EXIT_QPI  = 8'hF5;
  localparam logic [7:0] OP_READ      = 8'hEB;
  localparam logic [7:0] OP_WRITE     = 8'h38;

  localparam int unsigned WAIT_CYCLES  = 6;
  localparam int unsigned ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  // Bursts stay inside one page: only the low page_bits count, the rest is held.
  function automatic logic [23:0] page_incr(input logic [23:0] addr, input int unsigned page_bits);
    logic [23:0] mask;
    mask = (24'd1 << page_bits) - 24'd1;
    return (addr & ~mask) | ((addr + 24'd1) & mask);
  endfunction

endpackage

// File: rtl/psram_qpi_responder_if.sv
// Byte-wide backing-memory port of the PSRAM target model.
// master = responder side, slave = memory side (read data 1 clk after mem_re).
interface psram_qpi_responder_if #(
  parameter int ADDR_W = 24
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/psram_qpi_responder_pin_sync.sv
// Two-flop synchronizers for the PSRAM pins plus one-clk edge pulses of sclk and ce.
// sclk edges are suppressed while the synchronized ce is high.
module psram_qpi_responder_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ce,
  input  logic [3:0] sio_i,
  output logic       ce_s,
  output logic [3:0] sio_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       ce_rise,
  output logic       ce_fall
);

  logic       sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic       ce_meta_q, ce_meta_d, ce_sync_q, ce_sync_d, ce_prev_q, ce_prev_d;
  logic [3:0] sio_meta_q, sio_meta_d, sio_sync_q, sio_sync_d;

  always_comb begin
    sclk_meta_d = sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    ce_meta_d   = ce;
    ce_sync_d   = ce_meta_q;
    ce_prev_d   = ce_sync_q;
    sio_meta_d  = sio_i;
    sio_sync_d  = sio_meta_q;
  end

  // ce resets to the deselected level so no spurious select is seen after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      ce_meta_q   <= 1'b1;
      ce_sync_q   <= 1'b1;
      ce_prev_q   <= 1'b1;
      sio_meta_q  <= 4'h0;
      sio_sync_q  <= 4'h0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ce_meta_q   <= ce_meta_d;
      ce_sync_q   <= ce_sync_d;
      ce_prev_q   <= ce_prev_d;
      sio_meta_q  <= sio_meta_d;
      sio_sync_q  <= sio_sync_d;
    end
  end

  assign ce_s      = ce_sync_q;
  assign sio_s     = sio_sync_q;
  assign sclk_rise =  sclk_sync_q & ~sclk_prev_q & ~ce_sync_q;
  assign sclk_fall = ~sclk_sync_q &  sclk_prev_q & ~ce_sync_q;
  assign ce_rise   =  ce_sync_q & ~ce_prev_q;
  assign ce_fall   = ~ce_sync_q &  ce_prev_q;

endmodule

// File: rtl/psram_qpi_responder.sv
// Synthesizable ESP-PSRAM64H SPI/QPI target model mapping bursts onto a byte memory port.
// Define PSRAM_QPI_EXIT_EN to accept opcode 0xF5 as a QPI-exit command.
module psram_qpi_responder
  import psram_qpi_responder_pkg::*;
#(
  parameter int          ADDR_W    = 24,
  parameter int unsigned PAGE_BITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ce,
  input  logic [3:0]                   sio_i,
  output logic [3:0]                   sio_o,
  output logic [3:0]                   sio_oe,
  psram_qpi_responder_if.master        mem,
  output logic                         qpi_mode,
  output logic                         active
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_NIBBLES - 1);

  logic       ce_s, sclk_rise, sclk_fall, ce_rise, ce_fall;
  logic [3:0] sio_s;

  psram_qpi_responder_pin_sync u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ce        (ce),
    .sio_i     (sio_i),
    .ce_s      (ce_s),
    .sio_s     (sio_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ce_rise   (ce_rise),
    .ce_fall   (ce_fall)
  );

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [19:0]       shift_q, shift_d;
  logic              rsten_q, rsten_d;
  logic              qpi_q, qpi_d;
  logic              rd_q, rd_d;
  logic              nib_hi_q, nib_hi_d;
  logic [23:0]       addr_q, addr_d;
  logic [3:0]        wbuf_q, wbuf_d;
  logic [3:0]        lo_q, lo_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic              re_dly_q, re_dly_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [3:0]        sio_o_q, sio_o_d;
  logic [3:0]        sio_oe_q, sio_oe_d;
  logic              active_q, active_d;

  logic [7:0]  cmd_byte;
  logic        cmd_last;
  logic [23:0] addr_full;

  assign cmd_byte  = qpi_q ? {shift_q[3:0], sio_s} : {shift_q[6:0], sio_s[0]};
  assign cmd_last  = qpi_q ? (cnt_q == 3'd1) : (cnt_q == 3'd7);
  assign addr_full = {shift_q, sio_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rsten_d     = rsten_q;
    qpi_d       = qpi_q;
    rd_d        = rd_q;
    nib_hi_d    = nib_hi_q;
    addr_d      = addr_q;
    wbuf_d      = wbuf_q;
    lo_d        = lo_q;
    rbuf_d      = rbuf_q;
    re_dly_d    = mem_re_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    sio_o_d     = sio_o_q;
    sio_oe_d    = sio_oe_q;
    active_d    = ~ce_s;

    // Memory answers one clk after mem_re; keep the byte until its high-nibble fall.
    if (re_dly_q) rbuf_d = mem.mem_rdata;

    if (ce_rise || ce_fall) begin
      state_d = ST_CMD;
      cnt_d   = 3'd0;
    end else begin
      if (sclk_rise) begin
        case (state_q)
          ST_CMD: begin
            shift_d = qpi_q ? {shift_q[15:0], sio_s} : {shift_q[18:0], sio_s[0]};
            cnt_d   = cnt_q + 3'd1;
            if (cmd_last) begin
              state_d = ST_IGNORE;
              cnt_d   = 3'd0;
              rsten_d = 1'b0;
              case (cmd_byte)
                OP_RSTEN:     rsten_d = 1'b1;
                OP_RST:       if (rsten_q) qpi_d = 1'b0;
                OP_ENTER_QPI: if (!qpi_q) qpi_d = 1'b1;
`ifdef PSRAM_QPI_EXIT_EN
                OP_EXIT_QPI:  if (qpi_q) qpi_d = 1'b0;
`endif
                OP_READ: if (qpi_q) begin
                  state_d = ST_ADDR;
                  rd_d    = 1'b1;
                end
                OP_WRITE: if (qpi_q) begin
                  state_d = ST_ADDR;
                  rd_d    = 1'b0;
                end
                default: ;
              endcase
            end
          end
          ST_ADDR: begin
            shift_d = {shift_q[15:0], sio_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == ADDR_LAST) begin
              cnt_d = 3'd0;
              if (rd_q) begin
                state_d    = ST_WAIT;
                mem_re_d   = 1'b1;
                mem_addr_d = addr_full[ADDR_W-1:0];
                addr_d     = page_incr(addr_full, PAGE_BITS);
              end else begin
                state_d  = ST_WDATA;
                addr_d   = addr_full;
                nib_hi_d = 1'b1;
              end
            end
          end
          ST_WAIT: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == WAIT_LAST) begin
              state_d  = ST_RDATA;
              nib_hi_d = 1'b1;
            end
          end
          ST_WDATA: begin
            if (nib_hi_q) begin
              wbuf_d   = sio_s;
              nib_hi_d = 1'b0;
            end else begin
              mem_wdata_d = {wbuf_q, sio_s};
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q[ADDR_W-1:0];
              addr_d      = page_incr(addr_q, PAGE_BITS);
              nib_hi_d    = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // The fetch for the following byte is launched as soon as this byte is consumed.
      if (sclk_fall && state_q == ST_RDATA) begin
        sio_oe_d = 4'hF;
        if (nib_hi_q) begin
          sio_o_d    = rbuf_q[7:4];
          lo_d       = rbuf_q[3:0];
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q[ADDR_W-1:0];
          addr_d     = page_incr(addr_q, PAGE_BITS);
          nib_hi_d   = 1'b0;
        end else begin
          sio_o_d  = lo_q;
          nib_hi_d = 1'b1;
        end
      end
    end

    if (state_d != ST_RDATA) sio_oe_d = 4'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CMD;
      cnt_q       <= 3'd0;
      shift_q     <= 20'h0;
      rsten_q     <= 1'b0;
      qpi_q       <= 1'b0;
      rd_q        <= 1'b0;
      nib_hi_q    <= 1'b1;
      addr_q      <= 24'h0;
      wbuf_q      <= 4'h0;
      lo_q        <= 4'h0;
      rbuf_q      <= 8'h0;
      re_dly_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      sio_o_q     <= 4'h0;
      sio_oe_q    <= 4'h0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rsten_q     <= rsten_d;
      qpi_q       <= qpi_d;
      rd_q        <= rd_d;
      nib_hi_q    <= nib_hi_d;
      addr_q      <= addr_d;
      wbuf_q      <= wbuf_d;
      lo_q        <= lo_d;
      rbuf_q      <= rbuf_d;
      re_dly_q    <= re_dly_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      sio_o_q     <= sio_o_d;
      sio_oe_q    <= sio_oe_d;
      active_q    <= active_d;
    end
  end

  assign sio_o         = sio_o_q;
  assign sio_oe        = sio_oe_q;
  assign qpi_mode      = qpi_q;
  assign active        = active_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: acts as the PSRAM controller and the backing memory,
// and checks against a byte-array model of the device contents (honours PSRAM_QPI_EXIT_EN).
module tb_psram_qpi_responder;

  localparam int HALF = 80;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ce = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o, sio_oe;
  logic       qpi_mode, active;

  psram_qpi_responder_if #(.ADDR_W(24)) mem_if ();

  psram_qpi_responder #(.ADDR_W(24), .PAGE_BITS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ce       (ce),
    .sio_i    (sio_i),
    .sio_o    (sio_o),
    .sio_oe   (sio_oe),
    .mem      (mem_if),
    .qpi_mode (qpi_mode),
    .active   (active)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095] = '{default: 8'h00};
  logic [7:0] model_mem [0:4095] = '{default: 8'h00};
  logic [7:0] rdata_q = 8'h00;

  always @(posedge clk) begin
    if (mem_if.mem_we) ram[mem_if.mem_addr[11:0]] <= mem_if.mem_wdata;
    if (mem_if.mem_re) rdata_q <= ram[mem_if.mem_addr[11:0]];
  end
  assign mem_if.mem_rdata = rdata_q;

  int         vectors = 0;
  int         miscompares = 0;
  logic       sample_req = 1'b0;
  logic [3:0] exp_oe = 4'h0;
  logic [3:0] exp_nib = 4'h0;
  logic       oe_window = 1'b0;
  logic       rd_window = 1'b0;
  wr_t        exp_q [$];
  wr_t        cur_wr;
  logic [7:0] wr_buf [0:7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] modelNext(input logic [23:0] a);
    int unsigned v, page, off;
    v    = 32'(a);
    page = v / 1024;
    off  = ((v % 1024) + 1) % 1024;
    return 24'(page * 1024 + off);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (mem_if.mem_we) begin
        checkOutput("wr_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_wr = exp_q.pop_front();
          checkOutput("wr_addr", 32'(mem_if.mem_addr), 32'(cur_wr.a));
          checkOutput("wr_data", 32'(mem_if.mem_wdata), 32'(cur_wr.d));
        end
      end
      if (!rd_window) checkOutput("re_idle", 32'(mem_if.mem_re), 32'd0);
      if (!oe_window) checkOutput("oe_idle", 32'(sio_oe), 32'd0);
      if (sample_req) begin
        checkOutput("oe_at_rise", 32'(sio_oe), 32'(exp_oe));
        if (exp_oe == 4'hF) checkOutput("nibble", 32'(sio_o), 32'(exp_nib));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] d, input logic chk, input logic [3:0] eoe,
                               input logic [3:0] enib, output logic [3:0] smp);
    sio_i = d;
    #(HALF - 10);
    if (chk) begin
      exp_oe     = eoe;
      exp_nib    = enib;
      sample_req = 1'b1;
    end
    smp = sio_o;
    #10;
    sample_req = 1'b0;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic ceLow();
    ce = 1'b0;
    #HALF;
  endtask

  task automatic ceHigh();
    #HALF;
    ce    = 1'b1;
    sio_i = 4'h0;
    #(4 * HALF);
  endtask

  task automatic sendSpi(input logic [7:0] b);
    logic [3:0] smp;
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]}, 1'b0, 4'h0, 4'h0, smp);
  endtask

  task automatic sendQpi(input logic [7:0] b);
    logic [3:0] smp;
    applyStimulus(b[7:4], 1'b0, 4'h0, 4'h0, smp);
    applyStimulus(b[3:0], 1'b0, 4'h0, 4'h0, smp);
  endtask

  task automatic sendAddr(input logic [23:0] a);
    logic [3:0] smp;
    for (int i = 0; i < 6; i++) applyStimulus(a[23-4*i -: 4], 1'b0, 4'h0, 4'h0, smp);
  endtask

  task automatic spiCmd(input logic [7:0] b);
    ceLow();
    sendSpi(b);
    ceHigh();
  endtask

  task automatic qpiCmd(input logic [7:0] b);
    ceLow();
    sendQpi(b);
    ceHigh();
  endtask

  task automatic qpiWrite(input logic [23:0] a, input int n);
    logic [23:0] p;
    logic [3:0]  smp;
    ceLow();
    sendQpi(8'h38);
    sendAddr(a);
    p = a;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({p, wr_buf[k]});
      model_mem[p[11:0]] = wr_buf[k];
      p = modelNext(p);
      applyStimulus(wr_buf[k][7:4], 1'b0, 4'h0, 4'h0, smp);
      applyStimulus(wr_buf[k][3:0], 1'b0, 4'h0, 4'h0, smp);
    end
    ceHigh();
    checkOutput("wr_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Waits plus 2*n data clocks; every data clock is checked against the model contents.
  task automatic qpiStartRead(input logic [23:0] a, input int n, output logic [31:0] nibs);
    logic [23:0] p;
    logic [7:0]  e;
    logic [3:0]  smp;
    nibs      = 32'h0;
    rd_window = 1'b1;
    ceLow();
    sendQpi(8'hEB);
    sendAddr(a);
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, 1'b1, 4'h0, 4'h0, smp);
    oe_window = 1'b1;
    p = a;
    for (int k = 0; k < 2 * n; k++) begin
      e = model_mem[p[11:0]];
      applyStimulus(4'h0, 1'b1, 4'hF, (k % 2 == 0) ? e[7:4] : e[3:0], smp);
      nibs = {nibs[27:0], smp};
      if (k % 2 == 1) p = modelNext(p);
    end
  endtask

  task automatic qpiRead(input logic [23:0] a, input int n, output logic [31:0] nibs);
    qpiStartRead(a, n, nibs);
    ceHigh();
    oe_window = 1'b0;
    rd_window = 1'b0;
  endtask

  initial begin
    logic [31:0] nibs;

    #22;
    checkOutput("rst_sio_oe", 32'(sio_oe), 32'd0);
    checkOutput("rst_qpi", 32'(qpi_mode), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    rst = 1'b1;
    #100;

    $display("[TB] SPI reset-enable, reset, enter-QPI");
    ceLow();
    checkOutput("active_sel", 32'(active), 32'd1);
    sendSpi(8'h66);
    ceHigh();
    checkOutput("active_desel", 32'(active), 32'd0);
    checkOutput("qpi_after_66", 32'(qpi_mode), 32'd0);
    spiCmd(8'h99);
    checkOutput("qpi_after_99", 32'(qpi_mode), 32'd0);
    ceLow();
    sendSpi(8'hEB);
    for (int i = 0; i < 12; i++) sendQpi(8'h00);
    ceHigh();
    checkOutput("qpi_after_spi_eb", 32'(qpi_mode), 32'd0);
    spiCmd(8'h35);
    checkOutput("qpi_after_35", 32'(qpi_mode), 32'd1);

    $display("[TB] QPI write and read back at 0x10");
    wr_buf[0] = 8'hA5;
    wr_buf[1] = 8'h3C;
    qpiWrite(24'h000010, 2);
    checkOutput("ram_10", 32'(ram[12'h010]), 32'hA5);
    checkOutput("ram_11", 32'(ram[12'h011]), 32'h3C);
    qpiRead(24'h000010, 2, nibs);
    checkOutput("read_10_nibbles", nibs, 32'h0000A53C);

    $display("[TB] page wrap bursts");
    wr_buf[0] = 8'h5A;
    wr_buf[1] = 8'hC3;
    qpiWrite(24'h0003FF, 2);
    checkOutput("ram_3ff", 32'(ram[12'h3FF]), 32'h5A);
    checkOutput("ram_000", 32'(ram[12'h000]), 32'hC3);
    checkOutput("ram_400", 32'(ram[12'h400]), 32'h00);
    qpiRead(24'h0003FF, 2, nibs);
    checkOutput("read_3ff_nibbles", nibs, 32'h00005AC3);
    wr_buf[0] = 8'h11;
    wr_buf[1] = 8'h22;
    wr_buf[2] = 8'h33;
    qpiWrite(24'h0007FE, 3);
    qpiRead(24'h0007FE, 4, nibs);
    checkOutput("read_7fe_nibbles", nibs, 32'h11223300);

    $display("[TB] aborted write nibble");
    ceLow();
    sendQpi(8'h38);
    sendAddr(24'h000020);
    applyStimulus(4'h7, 1'b0, 4'h0, 4'h0, nibs[3:0]);
    ceHigh();
    checkOutput("ram_20_untouched", 32'(ram[12'h020]), 32'h00);
    wr_buf[0] = 8'h9E;
    qpiWrite(24'h000021, 1);
    checkOutput("ram_21", 32'(ram[12'h021]), 32'h9E);

    $display("[TB] QPI reset-enable sequencing");
    qpiCmd(8'h99);
    checkOutput("qpi_99_no_rsten", 32'(qpi_mode), 32'd1);
    qpiCmd(8'h66);
    qpiCmd(8'h35);
    qpiCmd(8'h99);
    checkOutput("qpi_rsten_cleared", 32'(qpi_mode), 32'd1);
    qpiCmd(8'h66);
    qpiCmd(8'h99);
    checkOutput("qpi_66_99_exit", 32'(qpi_mode), 32'd0);
    spiCmd(8'h35);
    checkOutput("qpi_reenter", 32'(qpi_mode), 32'd1);

    $display("[TB] opcode 0xF5 in QPI");
    qpiCmd(8'hF5);
`ifdef PSRAM_QPI_EXIT_EN
    checkOutput("qpi_after_f5", 32'(qpi_mode), 32'd0);
    spiCmd(8'h35);
`else
    checkOutput("qpi_after_f5", 32'(qpi_mode), 32'd1);
`endif

    $display("[TB] asynchronous reset during read");
    qpiStartRead(24'h000010, 1, nibs);
    checkOutput("pre_rst_nibbles", nibs, 32'h000000A5);
    #44;
    rst = 1'b0;
    #1;
    oe_window = 1'b0;
    checkOutput("arst_sio_oe", 32'(sio_oe), 32'd0);
    checkOutput("arst_sio_o", 32'(sio_o), 32'd0);
    checkOutput("arst_qpi", 32'(qpi_mode), 32'd0);
    checkOutput("arst_active", 32'(active), 32'd0);
    checkOutput("arst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    checkOutput("arst_mem_re", 32'(mem_if.mem_re), 32'd0);
    ce = 1'b1;
    sio_i = 4'h0;
    #50;
    rst = 1'b1;
    rd_window = 1'b0;
    #200;
    spiCmd(8'h35);
    checkOutput("qpi_after_rst", 32'(qpi_mode), 32'd1);
    wr_buf[0] = 8'h4D;
    qpiWrite(24'h000030, 1);
    checkOutput("ram_30", 32'(ram[12'h030]), 32'h4D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
